// File: rtl/frame_deserializer.sv
// Receive-side frame deserializer: locks onto HEADER, collects up to NUM_CHANNELS
// payload bytes into a shadow buffer and publishes them on FOOTER.
module frame_deserializer #(
  parameter int unsigned NUM_CHANNELS = 16,
  parameter logic [7:0]  HEADER       = 8'hAA,
  parameter logic [7:0]  FOOTER       = 8'h55
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  din,
  output logic [8*NUM_CHANNELS-1:0]   frame_data,
  output logic [4:0]                  frame_len,
  output logic                        frame_valid,
  output logic                        frame_err,
  output logic [7:0]                  err_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_FULL
  } state_e;

  localparam logic [4:0] LAST_COUNT = 5'(NUM_CHANNELS);

  state_e                      state_q, state_d;
  logic [8*NUM_CHANNELS-1:0]   shadow_q, shadow_d;
  logic [4:0]                  count_q, count_d;
  logic [8*NUM_CHANNELS-1:0]   frame_data_q, frame_data_d;
  logic [4:0]                  frame_len_q, frame_len_d;
  logic                        frame_valid_q, frame_valid_d;
  logic                        frame_err_q, frame_err_d;
  logic [7:0]                  err_count_q, err_count_d;
  logic                        good_frame, bad_frame;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    count_d       = count_q;
    frame_data_d  = frame_data_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_count_d   = err_count_q;
    good_frame    = 1'b0;
    bad_frame     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (din == HEADER) begin
          state_d  = ST_PAYLOAD;
          shadow_d = '0;
          count_d  = '0;
        end
      end
      ST_PAYLOAD: begin
        if (din == FOOTER) begin
          state_d = ST_IDLE;
          if (count_q != 5'd0) good_frame = 1'b1;
          else                 bad_frame  = 1'b1;
        end else begin
          // Decoded write keeps the index in range for any NUM_CHANNELS.
          for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            if (count_q == 5'(k)) shadow_d[8*k +: 8] = din;
          end
          count_d = count_q + 5'd1;
          if (count_d == LAST_COUNT) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (din == FOOTER) begin
          state_d    = ST_IDLE;
          good_frame = 1'b1;
        end else begin
          bad_frame = 1'b1;
          if (din == HEADER) begin
            // Overrunning HEADER is taken as the start of the next frame.
            state_d  = ST_PAYLOAD;
            shadow_d = '0;
            count_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (good_frame) begin
      frame_data_d  = shadow_q;
      frame_len_d   = count_q;
      frame_valid_d = 1'b1;
    end
    if (bad_frame) begin
      frame_err_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      count_q       <= '0;
      frame_data_q  <= '0;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      count_q       <= count_d;
      frame_data_q  <= frame_data_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_len   = frame_len_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench for frame_deserializer: directed frames plus random byte
// streams compared every cycle against a queue-based frame model.
module tb_frame_deserializer;

  localparam int unsigned NCH = 16;
  localparam logic [7:0]  HDR = 8'hAA;
  localparam logic [7:0]  FTR = 8'h55;

  logic             clk;
  logic             rst;
  logic [7:0]       din;
  logic [8*NCH-1:0] frame_data;
  logic [4:0]       frame_len;
  logic             frame_valid;
  logic             frame_err;
  logic [7:0]       err_count;

  frame_deserializer #(
    .NUM_CHANNELS(NCH),
    .HEADER      (HDR),
    .FOOTER      (FTR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .frame_data (frame_data),
    .frame_len  (frame_len),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model state
  logic [7:0]       pay_q[$];
  bit               in_frame;
  logic [8*NCH-1:0] exp_data;
  logic [4:0]       exp_len;
  logic             exp_valid;
  logic             exp_err;
  logic [7:0]       exp_err_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 128'(frame_valid), 128'(exp_valid));
    check({tag, "_err"},   128'(frame_err),   128'(exp_err));
    check({tag, "_len"},   128'(frame_len),   128'(exp_len));
    check({tag, "_data"},  128'(frame_data),  128'(exp_data));
    check({tag, "_ecnt"},  128'(err_count),   128'(exp_err_cnt));
  endtask

  task automatic model_reset();
    pay_q.delete();
    in_frame    = 1'b0;
    exp_data    = '0;
    exp_len     = '0;
    exp_valid   = 1'b0;
    exp_err     = 1'b0;
    exp_err_cnt = '0;
  endtask

  task automatic model_good();
    exp_data = '0;
    foreach (pay_q[i]) exp_data[8*i +: 8] = pay_q[i];
    exp_len   = 5'(pay_q.size());
    exp_valid = 1'b1;
  endtask

  task automatic model_bad();
    exp_err = 1'b1;
    if (exp_err_cnt != 8'd255) exp_err_cnt = exp_err_cnt + 8'd1;
  endtask

  task automatic model_step(input logic [7:0] b);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (!in_frame) begin
      if (b == HDR) begin
        in_frame = 1'b1;
        pay_q.delete();
      end
    end else if (b == FTR) begin
      if (pay_q.size() == 0) model_bad();
      else                   model_good();
      in_frame = 1'b0;
    end else if (pay_q.size() == NCH) begin
      model_bad();
      if (b == HDR) pay_q.delete();
      else          in_frame = 1'b0;
    end else begin
      pay_q.push_back(b);
    end
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    @(negedge clk);
    din = b;
    @(posedge clk);
    #1;
    model_step(b);
    check_outputs(tag);
  endtask

  function automatic logic [7:0] rand_payload();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (b == FTR);
    return b;
  endfunction

  task automatic send_full_payload(input string tag);
    for (int i = 0; i < NCH; i++) send(rand_payload(), tag);
  endtask

  logic [127:0] saved_data;

  initial begin
    rst = 1'b0;
    din = 8'h00;
    model_reset();
    #2 rst = 1'b1;
    #1;
    check_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Short frame
    send(HDR, "short"); send(8'hA1, "short"); send(8'hB2, "short");
    send(8'hC3, "short"); send(8'hD4, "short"); send(FTR, "short_end");
    check("short_fixed_valid", 128'(frame_valid), 128'd1);
    check("short_fixed_len",   128'(frame_len),   128'd4);
    check("short_fixed_data",  frame_data, 128'hD4C3B2A1);
    send(8'h00, "short_after");
    check("short_pulse_1cyc", 128'(frame_valid), 128'd0);

    // Full frame
    send(HDR, "full"); send_full_payload("full"); send(FTR, "full_end");
    check("full_len_fixed", 128'(frame_len), 128'd16);

    // Overrun keeps previous good frame
    saved_data = frame_data;
    send(HDR, "ovr"); send_full_payload("ovr"); send(8'h3C, "ovr_end");
    check("ovr_err_fixed",  128'(frame_err), 128'd1);
    check("ovr_ecnt_fixed", 128'(err_count), 128'd1);
    check("ovr_hold_data",  frame_data, saved_data);

    // Empty frame, then overrun with resync
    send(HDR, "empty"); send(FTR, "empty_end");
    send(HDR, "resync"); send_full_payload("resync");
    send(HDR, "resync_hdr");
    check("resync_err_fixed", 128'(frame_err), 128'd1);
    send(8'h01, "resync"); send(FTR, "resync_end");
    check("resync_len_fixed", 128'(frame_len), 128'd1);
    check("resync_ch0_fixed", frame_data, 128'h01);

    // Back-to-back with leading idle
    send(8'h00, "b2b"); send(8'h00, "b2b"); send(HDR, "b2b");
    send(8'h11, "b2b"); send(FTR, "b2b_end1"); send(HDR, "b2b");
    send(8'h22, "b2b"); send(FTR, "b2b_end2");
    check("b2b_data_fixed", frame_data, 128'h22);

    // Reset mid-frame
    send(HDR, "rstmid"); send(8'h11, "rstmid"); send(8'h22, "rstmid");
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rstmid_async");
    @(negedge clk);
    rst = 1'b0;
    send(FTR, "rstmid_ftr");
    send(HDR, "rstmid2"); send(8'h33, "rstmid2"); send(FTR, "rstmid2_end");
    check("rstmid2_data_fixed", frame_data, 128'h33);

    // Random frames of length 0..17 with 0..2 idle bytes between them
    for (int f = 0; f < 200; f++) begin
      int unsigned len;
      int unsigned idle;
      len  = $urandom_range(0, 17);
      idle = $urandom_range(0, 2);
      for (int unsigned i = 0; i < idle; i++) send(rand_payload() & 8'h0F, "rfr_idle");
      send(HDR, "rfr");
      for (int unsigned i = 0; i < len; i++) send(rand_payload(), "rfr");
      send(FTR, "rfr_end");
    end

    // Unstructured random stream biased toward HEADER/FOOTER
    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 2)      send(HDR, "rstream");
      else if (r < 4) send(FTR, "rstream");
      else            send(8'($urandom_range(0, 255)), "rstream");
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      send(HDR, "sat"); send(FTR, "sat");
    end
    check("sat_ecnt_fixed", 128'(err_count), 128'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_deserializer.md
# frame_deserializer

Receive-side counterpart of `serializer`. Consumes its 8-bit byte stream, locks onto `HEADER`, and collects up to `NUM_CHANNELS` payload bytes into a parallel channel vector until `FOOTER` arrives. Each frame is reported with a one-cycle valid or error pulse. Sits directly downstream of `serializer`: `serializer.dout` feeds `din` here.

## Interface
- `NUM_CHANNELS`, default 16: maximum payload bytes per frame (range 1..16).
- `HEADER`, default 8'hAA: frame start byte.
- `FOOTER`, default 8'h55: frame end byte. Reserved; never valid as payload.
- `clk`  input  1: single clock. All logic is on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `din`  input  8: byte stream from `serializer`, sampled every cycle.
- `frame_data`  output  8*NUM_CHANNELS: channel k is in bits [8k+7:8k]; channel 0 is the first payload byte.
- `frame_len`  output  5: number of payload bytes in the last good frame.
- `frame_valid`  output  1: one-cycle pulse for a good frame.
- `frame_err`  output  1: one-cycle pulse for a malformed frame.
- `err_count`  output  8: saturating count of `frame_err` pulses.

## Operation
- Frame format: `HEADER`, then 1..`NUM_CHANNELS` payload bytes, then `FOOTER`. Any non-`HEADER` byte outside a frame is idle and is ignored.
- FSM states:
  - IDLE:
    - `din`==`HEADER` → go to PAYLOAD, clear shadow buffer and count.
    - Any other byte → stay in IDLE.
  - PAYLOAD:
    - `din`==`FOOTER` with count ≥1 → good frame, go to IDLE.
    - `din`==`FOOTER` with count 0 → error, go to IDLE.
    - Any other byte → write to shadow[count], increment count. If count reaches `NUM_CHANNELS`, go to FULL.
    - `HEADER` bytes inside PAYLOAD are ordinary payload.
  - FULL:
    - `din`==`FOOTER` → good frame, go to IDLE.
    - `din`==`HEADER` → error, then go directly to PAYLOAD (resync: this byte is the new frame's header).
    - Any other byte → error, go to IDLE.
- Good frame:
  - Copy shadow → `frame_data`. Channels ≥ count read 0.
  - `frame_len` ← count.
  - Pulse `frame_valid`.
- Error:
  - Pulse `frame_err`; `frame_data` and `frame_len` are unchanged.
  - `err_count` increments and saturates at 255.
- Shadow buffer is separate from `frame_data`. `frame_data` changes only on a good frame and holds until the next one.
- A new `HEADER` may follow `FOOTER` on the very next cycle; zero idle bytes are required.

## Timing
- Reset (asynchronous assert): FSM in IDLE, count 0, and every output is 0 (`frame_data`, `frame_len`, `frame_valid`, `frame_err`, `err_count`).
- Reset asserted mid-frame discards the partial frame. No pulse is produced.
- All outputs are registered. `frame_valid`/`frame_err` assert in the cycle after the terminating byte is sampled, and last exactly one cycle.
- `frame_data`/`frame_len` update in the same cycle that `frame_valid` asserts.
- Latency from `FOOTER` sample to `frame_valid` is 1 cycle. The minimum frame is 3 bytes (`HEADER`, one payload byte, `FOOTER`), so the peak rate is one `frame_valid` per 3 cycles.
- `frame_valid` and `frame_err` are never high in the same cycle.

## Test plan
- Short frame: AA, A1, B2, C3, D4, 55 → `frame_valid` 1 cycle after 55; `frame_len`=4; ch0..3 = A1,B2,C3,D4; ch4..15 = 0.
- Full frame: AA, 16 random non-55 bytes, 55 → `frame_len`=16; all channels match the sent order; no `frame_err`.
- Overrun: AA, 16 bytes, 3C → `frame_err` pulse; `err_count`=1; `frame_data` still holds the previous good frame.
- Empty and resync:
  - AA, 55 → `frame_err`.
  - AA, 16 bytes, AA, 01, 55 → one `frame_err`, then `frame_valid` with `frame_len`=1, ch0=01.
- Back-to-back and idle: 00 00 AA 11 55 AA 22 55 → two `frame_valid` pulses 3 cycles apart; second pulse has ch0=22, `frame_len`=1.
- Reset mid-frame: `rst` pulse after AA, 11, 22; then 55 → no pulse; all outputs 0. A following AA 33 55 gives `frame_len`=1, ch0=33.
